// File: rtl/spi_ram.sv
// Command-decoding single-port RAM fed by the SPI slave's 10-bit words ([9:8] cmd, [7:0] payload).
// Define SPI_RAM_AUTO_INC_EN to post-increment the write/read addresses after each data command.
module spi_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid
);

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  logic [7:0]           mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 mem_we;
  cmd_e                 cmd;

  assign cmd = cmd_e'(rx_data[9:8]);

  always_comb begin
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    mem_we     = 1'b0;
    if (rx_valid) begin
      case (cmd)
        CMD_WR_ADDR: wr_addr_d = rx_data[ADDR_SIZE-1:0];
        CMD_WR_DATA: begin
          mem_we = 1'b1;
`ifdef SPI_RAM_AUTO_INC_EN
          wr_addr_d = wr_addr_q + ADDR_SIZE'(1);
`else
          wr_addr_d = wr_addr_q;
`endif
        end
        CMD_RD_ADDR: rd_addr_d = rx_data[ADDR_SIZE-1:0];
        CMD_RD_DATA: begin
          tx_data_d  = mem[rd_addr_q];
          tx_valid_d = 1'b1;
`ifdef SPI_RAM_AUTO_INC_EN
          rd_addr_d = rd_addr_q + ADDR_SIZE'(1);
`else
          rd_addr_d = rd_addr_q;
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  // Storage is never cleared; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[wr_addr_q] <= rx_data[7:0];
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;

endmodule

// File: tb/tb_spi_ram.sv
// Directed bench for spi_ram: vector table plus reset and qualifier sequences.
module tb_spi_ram;

  logic       clk;
  logic       rst;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int tests;
  int fails;

  typedef struct {
    logic       v;
    logic [9:0] d;
    logic       ev;
    logic [7:0] ed;
  } vec_t;

  vec_t vecs[$];

`ifdef SPI_RAM_AUTO_INC_EN
  localparam logic [7:0] RD_FF = 8'h11;
  localparam logic [7:0] RD_00 = 8'h22;
`else
  localparam logic [7:0] RD_FF = 8'h22;
  localparam logic [7:0] RD_00 = 8'h77;
`endif

  spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic v, input logic [9:0] d, input logic ev, input logic [7:0] ed);
    vec_t r;
    r.v = v; r.d = d; r.ev = ev; r.ed = ed;
    vecs.push_back(r);
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic v, input logic [9:0] d);
    @(negedge clk);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input string name, input vec_t r);
    step(r.v, r.d);
    chk({name, ".tx_valid"}, {7'd0, tx_valid}, {7'd0, r.ev});
    chk({name, ".tx_data"}, tx_data, r.ed);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    rx_valid = 1'b0;
    rx_data = 10'h000;

    // Asynchronous reset, asserted before any clock edge
    #3 rst = 1'b1;
    #1;
    chk("rst_async.tx_valid", {7'd0, tx_valid}, 8'h00);
    chk("rst_async.tx_data", tx_data, 8'h00);
    step(1'b1, 10'h1AA);
    chk("rst_hold0.tx_valid", {7'd0, tx_valid}, 8'h00);
    step(1'b1, 10'h300);
    chk("rst_hold1.tx_valid", {7'd0, tx_valid}, 8'h00);
    chk("rst_hold1.tx_data", tx_data, 8'h00);
    step(1'b1, 10'h255);
    chk("rst_hold2.tx_data", tx_data, 8'h00);
    @(negedge clk);
    rx_valid = 1'b0;
    rst = 1'b0;

    // Basic write/read
    add(0, 10'h000, 0, 8'h00);
    add(1, 10'h03A, 0, 8'h00);
    add(1, 10'h15C, 0, 8'h00);
    add(1, 10'h23A, 0, 8'h00);
    add(1, 10'h300, 1, 8'h5C);
    add(0, 10'h3FF, 0, 8'h5C);
    // Back-to-back
    add(1, 10'h0FF, 0, 8'h5C);
    add(1, 10'h1A5, 0, 8'h5C);
    add(1, 10'h2FF, 0, 8'h5C);
    add(1, 10'h3C7, 1, 8'hA5);
    add(0, 10'h000, 0, 8'hA5);
    // Write on cycle N, read same address on N+1
    add(1, 10'h010, 0, 8'hA5);
    add(1, 10'h210, 0, 8'hA5);
    add(1, 10'h1C3, 0, 8'hA5);
    add(1, 10'h300, 1, 8'hC3);
    add(0, 10'h000, 0, 8'hC3);
    // Seed address 0, then auto-increment / wrap scenario
    add(1, 10'h000, 0, 8'hC3);
    add(1, 10'h177, 0, 8'hC3);
    add(1, 10'h0FF, 0, 8'hC3);
    add(1, 10'h111, 0, 8'hC3);
    add(1, 10'h122, 0, 8'hC3);
    add(1, 10'h2FF, 0, 8'hC3);
    add(1, 10'h300, 1, RD_FF);
    add(0, 10'h000, 0, RD_FF);
    add(1, 10'h200, 0, RD_FF);
    add(1, 10'h300, 1, RD_00);
    add(0, 10'h000, 0, RD_00);
    // Park addresses for the qualifier sweep
    add(1, 10'h020, 0, RD_00);
    add(1, 10'h210, 0, RD_00);

    for (int i = 0; i < vecs.size(); i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Qualifier: every code with rx_valid low is ignored
    for (int c = 0; c < 1024; c++) begin
      step(1'b0, c[9:0]);
      chk($sformatf("sweep%0d.tx_valid", c), {7'd0, tx_valid}, 8'h00);
    end
    chk("sweep.tx_data", tx_data, RD_00);
    run_vec("post_sweep_rd", '{v: 1'b1, d: 10'h300, ev: 1'b1, ed: 8'hC3});
    run_vec("post_sweep_wr", '{v: 1'b1, d: 10'h155, ev: 1'b0, ed: 8'hC3});
    run_vec("post_sweep_ra", '{v: 1'b1, d: 10'h220, ev: 1'b0, ed: 8'hC3});
    run_vec("post_sweep_rd2", '{v: 1'b1, d: 10'h300, ev: 1'b1, ed: 8'h55});

    // Reset during the tx_valid cycle
    run_vec("mid_ra", '{v: 1'b1, d: 10'h210, ev: 1'b0, ed: 8'h55});
    run_vec("mid_rd", '{v: 1'b1, d: 10'h300, ev: 1'b1, ed: 8'hC3});
    #2 rst = 1'b1;
    #1;
    chk("mid_rst.tx_valid", {7'd0, tx_valid}, 8'h00);
    chk("mid_rst.tx_data", tx_data, 8'h00);
    step(1'b1, 10'h1AA);
    chk("mid_hold0.tx_valid", {7'd0, tx_valid}, 8'h00);
    step(1'b1, 10'h3AA);
    chk("mid_hold1.tx_valid", {7'd0, tx_valid}, 8'h00);
    step(1'b1, 10'h0AA);
    chk("mid_hold2.tx_data", tx_data, 8'h00);
    @(negedge clk);
    rx_valid = 1'b0;
    rst = 1'b0;
    run_vec("post_rst_rd0", '{v: 1'b1, d: 10'h300, ev: 1'b1, ed: RD_00});
    run_vec("post_rst_wr0", '{v: 1'b1, d: 10'h1E7, ev: 1'b0, ed: RD_00});
    run_vec("post_rst_ra0", '{v: 1'b1, d: 10'h200, ev: 1'b0, ed: RD_00});
    run_vec("post_rst_rd1", '{v: 1'b1, d: 10'h300, ev: 1'b1, ed: 8'hE7});
    run_vec("post_rst_idle", '{v: 1'b0, d: 10'h300, ev: 1'b0, ed: 8'hE7});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
